// File: rtl/vga_frame_copier.sv
// vga_frame_copier: copies a packed image out of one bank of the data
// memory into the VGA pixel memory. Each memory word is read, held in a
// shift register and written out as PPW pixels, least-significant slice
// first, each one tagged with its x/y screen coordinate. A frame can be
// copied once per request or back-to-back while the request is held.
module vga_frame_copier #(
    parameter int XLEN       = 32,
    parameter int DMEM_WIDTH = 14,
    parameter int PIX_W      = 8,
    parameter int H_RES      = 160,
    parameter int V_RES      = 120,
    parameter int X_W        = 8,
    parameter int Y_W        = 7,
    parameter int NUM_BLOCKS = 4,
    parameter int BASE_ADDR  = 0,
    localparam int SEL_W     = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       continuous,
    input  logic [SEL_W-1:0]           block_sel,
    input  logic [NUM_BLOCKS*XLEN-1:0] data_in,
    output logic [DMEM_WIDTH-1:0]      mem_addr,
    output logic                       mem_rd_en,
    output logic [XLEN/8-1:0]          byte_en,
    output logic [PIX_W-1:0]           mem_out,
    output logic [X_W-1:0]             mem_wr_x_addr,
    output logic [Y_W-1:0]             mem_wr_y_addr,
    output logic                       mem_wr_en,
    output logic                       busy,
    output logic                       frame_done
);

    // Pixels packed into one memory word, and the width of the counter
    // that walks through them.
    localparam int PPW   = XLEN / PIX_W;
    localparam int CNT_W = (PPW > 1) ? $clog2(PPW) : 1;

    localparam logic [X_W-1:0]        X_LAST   = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0]        Y_LAST   = Y_W'(V_RES - 1);
    localparam logic [CNT_W-1:0]      PIX_LAST = CNT_W'(PPW - 1);
    localparam logic [DMEM_WIDTH-1:0] BASE     = DMEM_WIDTH'(BASE_ADDR);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        WAIT   = 3'd2,
        UNPACK = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t                 state_reg;
    state_t                 state_next;

    logic [SEL_W-1:0]       sel_reg;
    logic [DMEM_WIDTH-1:0]  word_idx_reg;
    logic [X_W-1:0]         x_reg;
    logic [Y_W-1:0]         y_reg;
    logic [CNT_W-1:0]       pix_cnt_reg;
    logic [XLEN-1:0]        shift_reg;
    logic [X_W-1:0]         last_x_reg;
    logic [Y_W-1:0]         last_y_reg;
    logic                   busy_reg;

    // Decoded controls from the next-state logic.
    logic                   restart;
    logic                   rd_phase;
    logic                   wr_phase;

    // Coordinate / word-position flags for the pixel being written now.
    logic                   at_x_last;
    logic                   at_y_last;
    logic                   at_pix_last;
    logic                   frame_end;

    // Read data split into one word per bank.
    logic [XLEN-1:0]        banks [NUM_BLOCKS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BLOCKS; gi++) begin : g_bank
            assign banks[gi] = data_in[gi*XLEN +: XLEN];
        end
    endgenerate

    assign at_x_last   = (x_reg == X_LAST);
    assign at_y_last   = (y_reg == Y_LAST);
    assign at_pix_last = (pix_cnt_reg == PIX_LAST);
    assign frame_end   = at_x_last && at_y_last;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and strobe decode; everything idles to zero by default.
    always_comb begin
        state_next = state_reg;
        restart    = 1'b0;
        rd_phase   = 1'b0;
        wr_phase   = 1'b0;
        frame_done = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    restart    = 1'b1;
                    state_next = READ;
                end
            end
            READ: begin
                rd_phase   = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                state_next = UNPACK;
            end
            UNPACK: begin
                wr_phase = 1'b1;
                if (frame_end) begin
                    state_next = DONE;
                end else if (at_pix_last) begin
                    state_next = READ;
                end
            end
            DONE: begin
                frame_done = 1'b1;
                if (continuous && start) begin
                    restart    = 1'b1;
                    state_next = READ;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Bank latch, word/pixel counters, shift word and held coordinates.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sel_reg      <= '0;
            word_idx_reg <= '0;
            x_reg        <= '0;
            y_reg        <= '0;
            pix_cnt_reg  <= '0;
            shift_reg    <= '0;
            last_x_reg   <= '0;
            last_y_reg   <= '0;
        end else begin
            if (restart) begin
                sel_reg      <= block_sel;
                word_idx_reg <= '0;
                x_reg        <= '0;
                y_reg        <= '0;
                pix_cnt_reg  <= '0;
            end
            // The read issued in READ returns during WAIT.
            if (state_reg == WAIT) begin
                shift_reg <= banks[sel_reg];
            end
            if (wr_phase) begin
                shift_reg  <= shift_reg >> PIX_W;
                last_x_reg <= x_reg;
                last_y_reg <= y_reg;
                if (at_x_last) begin
                    x_reg <= '0;
                    y_reg <= y_reg + Y_W'(1);
                end else begin
                    x_reg <= x_reg + X_W'(1);
                end
                if (at_pix_last) begin
                    pix_cnt_reg  <= '0;
                    word_idx_reg <= word_idx_reg + DMEM_WIDTH'(1);
                end else begin
                    pix_cnt_reg <= pix_cnt_reg + CNT_W'(1);
                end
            end
        end
    end

    // Busy covers the whole frame including the DONE cycle; it only falls
    // when the engine returns to IDLE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_reg <= 1'b0;
        end else if (restart) begin
            busy_reg <= 1'b1;
        end else if (state_reg == DONE) begin
            busy_reg <= 1'b0;
        end
    end

    // Address wraps naturally at the memory width; it reads zero when idle.
    assign mem_addr      = rd_phase ? (BASE + word_idx_reg) : '0;
    assign mem_rd_en     = rd_phase;
    assign byte_en       = rd_phase ? '1 : '0;
    assign mem_wr_en     = wr_phase;
    assign mem_out       = wr_phase ? shift_reg[PIX_W-1:0] : '0;
    // Coordinates are live while writing and hold the last pixel otherwise.
    assign mem_wr_x_addr = wr_phase ? x_reg : last_x_reg;
    assign mem_wr_y_addr = wr_phase ? y_reg : last_y_reg;
    assign busy          = busy_reg;

endmodule
